// File: rtl/wf_limit_slew.sv
// Slews the live waveform window edges toward the target edges by up to STEP pixels per frame,
// and registers per-pixel in_window / on_border flags against the pre-update edges.
module wf_limit_slew #(
  parameter int WIDTH       = 10,
  parameter int STEP        = 2,
  parameter int DEF_START_X = 138,
  parameter int DEF_END_X   = 838,
  parameter int DEF_START_Y = 62,
  parameter int DEF_END_Y   = 482
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_tick,
  input  logic [WIDTH-1:0] tgt_start_x,
  input  logic [WIDTH-1:0] tgt_end_x,
  input  logic [WIDTH-1:0] tgt_start_y,
  input  logic [WIDTH-1:0] tgt_end_y,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] cur_start_x,
  output logic [WIDTH-1:0] cur_end_x,
  output logic [WIDTH-1:0] cur_start_y,
  output logic [WIDTH-1:0] cur_end_y,
  output logic             in_window,
  output logic             on_border,
  output logic             busy,
  output logic             settled
);

  typedef enum logic {IDLE, SLEW} state_t;

  localparam logic [WIDTH:0]   STEP_W = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

  state_t state;

  logic             x_ok, y_ok;
  logic [WIDTH-1:0] nxt_start_x, nxt_end_x, nxt_start_y, nxt_end_y;
  logic             at_tgt_now, at_tgt_next;
  logic             win_hit, edge_hit;

  // Move one edge toward its target by at most STEP; the difference is taken one bit wider.
  function automatic logic [WIDTH-1:0] slew_edge(input logic [WIDTH-1:0] cur,
                                                 input logic [WIDTH-1:0] tgt);
    logic [WIDTH:0] diff;
    if (cur < tgt) begin
      diff = {1'b0, tgt} - {1'b0, cur};
      return (diff > STEP_W) ? cur + STEP_W[WIDTH-1:0] : tgt;
    end else if (cur > tgt) begin
      diff = {1'b0, cur} - {1'b0, tgt};
      return (diff > STEP_W) ? cur - STEP_W[WIDTH-1:0] : tgt;
    end
    return cur;
  endfunction

  always_comb begin
    x_ok = tgt_start_x < tgt_end_x;
    y_ok = tgt_start_y < tgt_end_y;

    nxt_start_x = cur_start_x;
    nxt_end_x   = cur_end_x;
    nxt_start_y = cur_start_y;
    nxt_end_y   = cur_end_y;
    if (x_ok) begin
      nxt_start_x = slew_edge(cur_start_x, tgt_start_x);
      nxt_end_x   = slew_edge(cur_end_x,   tgt_end_x);
    end
    if (y_ok) begin
      nxt_start_y = slew_edge(cur_start_y, tgt_start_y);
      nxt_end_y   = slew_edge(cur_end_y,   tgt_end_y);
    end

    // An invalid axis never moves, so it is treated as already at target.
    at_tgt_now  = (!x_ok || (cur_start_x == tgt_start_x && cur_end_x == tgt_end_x)) &&
                  (!y_ok || (cur_start_y == tgt_start_y && cur_end_y == tgt_end_y));
    at_tgt_next = (!x_ok || (nxt_start_x == tgt_start_x && nxt_end_x == tgt_end_x)) &&
                  (!y_ok || (nxt_start_y == tgt_start_y && nxt_end_y == tgt_end_y));

    win_hit  = (x >= cur_start_x) && (x < cur_end_x) &&
               (y >= cur_start_y) && (y < cur_end_y);
    edge_hit = (x == cur_start_x) || (x == cur_end_x - ONE) ||
               (y == cur_start_y) || (y == cur_end_y - ONE);
  end

  assign busy = (state == SLEW);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      cur_start_x <= WIDTH'(DEF_START_X);
      cur_end_x   <= WIDTH'(DEF_END_X);
      cur_start_y <= WIDTH'(DEF_START_Y);
      cur_end_y   <= WIDTH'(DEF_END_Y);
      settled     <= 1'b0;
      in_window   <= 1'b0;
      on_border   <= 1'b0;
    end else begin
      settled   <= 1'b0;
      in_window <= win_hit;
      on_border <= win_hit && edge_hit;
      case (state)
        IDLE: begin
          if (frame_tick && !at_tgt_now) begin
            cur_start_x <= nxt_start_x;
            cur_end_x   <= nxt_end_x;
            cur_start_y <= nxt_start_y;
            cur_end_y   <= nxt_end_y;
            if (at_tgt_next) settled <= 1'b1;
            else             state   <= SLEW;
          end
        end
        SLEW: begin
          if (frame_tick) begin
            cur_start_x <= nxt_start_x;
            cur_end_x   <= nxt_end_x;
            cur_start_y <= nxt_start_y;
            cur_end_y   <= nxt_end_y;
            if (at_tgt_next) begin
              state   <= IDLE;
              settled <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wf_limit_slew.sv
// Directed-vector bench for wf_limit_slew: reset, slewing, no-overshoot, retarget, invalid axis,
// window flags and reset mid-slew, with hand-computed expected values.
module tb_wf_limit_slew;

  localparam int W = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         frame_tick = 1'b0;
  logic [W-1:0] tgt_start_x = 10'd138, tgt_end_x = 10'd838;
  logic [W-1:0] tgt_start_y = 10'd62,  tgt_end_y = 10'd482;
  logic [W-1:0] x = '0, y = '0;
  logic [W-1:0] cur_start_x, cur_end_x, cur_start_y, cur_end_y;
  logic         in_window, on_border, busy, settled;

  int n_checks = 0;
  int n_errors = 0;

  wf_limit_slew #(
    .WIDTH(W), .STEP(2),
    .DEF_START_X(138), .DEF_END_X(838), .DEF_START_Y(62), .DEF_END_Y(482)
  ) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .tgt_start_x(tgt_start_x), .tgt_end_x(tgt_end_x),
    .tgt_start_y(tgt_start_y), .tgt_end_y(tgt_end_y),
    .x(x), .y(y),
    .cur_start_x(cur_start_x), .cur_end_x(cur_end_x),
    .cur_start_y(cur_start_y), .cur_end_y(cur_end_y),
    .in_window(in_window), .on_border(on_border),
    .busy(busy), .settled(settled)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  task automatic set_tgt(input int sx, input int ex, input int sy, input int ey);
    tgt_start_x = W'(sx); tgt_end_x = W'(ex);
    tgt_start_y = W'(sy); tgt_end_y = W'(ey);
  endtask

  task automatic check_edges(input string tag, input int sx, input int ex, input int sy, input int ey);
    check({tag, ".sx"}, 32'(cur_start_x), 32'(sx));
    check({tag, ".ex"}, 32'(cur_end_x),   32'(ex));
    check({tag, ".sy"}, 32'(cur_start_y), 32'(sy));
    check({tag, ".ey"}, 32'(cur_end_y),   32'(ey));
  endtask

  initial begin
    step();

    // 1: reset state, with a frame_tick present that must be ignored
    set_tgt(88, 888, 32, 512);
    frame_tick = 1'b1;
    rst = 1'b0;
    step();
    frame_tick = 1'b0;
    rst = 1'b1;
    check_edges("rst", 138, 838, 62, 482);
    check("rst.busy", 32'(busy), 0);
    check("rst.settled", 32'(settled), 0);
    check("rst.in_window", 32'(in_window), 0);

    // 2: full slew to 88/888/32/512
    frame();
    check_edges("t1", 136, 840, 60, 484);
    check("t1.busy", 32'(busy), 1);
    for (int k = 2; k <= 24; k++) begin
      frame();
      if (k == 15) begin
        check_edges("t15", 108, 868, 32, 512);
        check("t15.busy", 32'(busy), 1);
      end
      check("t_mid.settled", 32'(settled), 0);
    end
    check("t24.busy", 32'(busy), 1);
    frame();
    check_edges("t25", 88, 888, 32, 512);
    check("t25.settled", 32'(settled), 1);
    check("t25.busy", 32'(busy), 0);
    step();
    check("t25+1.settled", 32'(settled), 0);

    // 3: single-pixel move, no overshoot, settles without entering SLEW
    do_reset();
    set_tgt(137, 838, 62, 482);
    frame();
    check("ov.sx", 32'(cur_start_x), 137);
    check("ov.settled", 32'(settled), 1);
    check("ov.busy", 32'(busy), 0);
    step();
    check("ov+1.settled", 32'(settled), 0);
    frame();
    check("ov.eq.settled", 32'(settled), 0);
    check("ov.eq.sx", 32'(cur_start_x), 137);

    // 4: retarget mid-slew reverses direction; edges hold without frame_tick
    do_reset();
    set_tgt(88, 838, 62, 482);
    for (int k = 0; k < 5; k++) frame();
    check("rt.sx5", 32'(cur_start_x), 128);
    check("rt.busy5", 32'(busy), 1);
    set_tgt(138, 838, 62, 482);
    frame();
    check("rt.sx6", 32'(cur_start_x), 130);
    set_tgt(300, 700, 100, 400);
    for (int k = 0; k < 100; k++) step();
    check_edges("hold", 130, 838, 62, 482);
    check("hold.busy", 32'(busy), 1);
    set_tgt(138, 838, 62, 482);
    for (int k = 0; k < 3; k++) frame();
    check("rt.sx9", 32'(cur_start_x), 136);
    check("rt.settled9", 32'(settled), 0);
    frame();
    check("rt.sx10", 32'(cur_start_x), 138);
    check("rt.settled10", 32'(settled), 1);
    check("rt.busy10", 32'(busy), 0);

    // 5: invalid x axis holds; y slews and drives settle
    do_reset();
    set_tgt(900, 838, 32, 512);
    for (int k = 0; k < 14; k++) frame();
    check_edges("inv14", 138, 838, 34, 510);
    check("inv14.busy", 32'(busy), 1);
    check("inv14.settled", 32'(settled), 0);
    frame();
    check_edges("inv15", 138, 838, 32, 512);
    check("inv15.settled", 32'(settled), 1);
    check("inv15.busy", 32'(busy), 0);

    // 6: window flags on default window
    do_reset();
    set_tgt(138, 838, 62, 482);
    x = 10'd138; y = 10'd62;  step();
    check("win.corner.in", 32'(in_window), 1);
    check("win.corner.bd", 32'(on_border), 1);
    x = 10'd400; y = 10'd300; step();
    check("win.mid.in", 32'(in_window), 1);
    check("win.mid.bd", 32'(on_border), 0);
    x = 10'd838; y = 10'd300; step();
    check("win.xend.in", 32'(in_window), 0);
    check("win.xend.bd", 32'(on_border), 0);
    x = 10'd837; y = 10'd300; step();
    check("win.xlast.in", 32'(in_window), 1);
    check("win.xlast.bd", 32'(on_border), 1);
    x = 10'd400; y = 10'd61;  step();
    check("win.yabove.in", 32'(in_window), 0);
    x = 10'd400; y = 10'd481; step();
    check("win.ylast.bd", 32'(on_border), 1);

    // flags use pre-update edges: x=137 after a tick that moves start_x to 136
    set_tgt(88, 888, 32, 512);
    x = 10'd137; y = 10'd300;
    frame();
    check("win.pre.in", 32'(in_window), 0);
    step();
    check("win.post.in", 32'(in_window), 1);

    // reset mid-slew snaps to defaults
    frame();
    check("mid.busy", 32'(busy), 1);
    do_reset();
    check_edges("midrst", 138, 838, 62, 482);
    check("midrst.busy", 32'(busy), 0);
    check("midrst.settled", 32'(settled), 0);
    check("midrst.in_window", 32'(in_window), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
